fetch_ctrl: RTL and testbench
=============================

// Module: fetch_ctrl
// PURPOSE
//  - PC/fetch sequencer directly upstream of the AXI instruction-fetch wrapper.
//  - Drives fetch address and request (io_pc / io_mem_flag); accepts io_inst on io_inst_valid/io_inst_ready.
//  - Presents {pc, inst} to decode over a valid/ready port.
//  - Applies branch/jump redirects, including redirects that arrive while a fetch is in flight.
// PARAMETERS
//  - RESET_PC  64'h0000_0000_8000_0000  PC of first fetch after reset.
//  - XLEN      64                       PC width.
// PORTS
//  - clock               in   1     sole clock, rising edge.
//  - reset               in   1     asynchronous assert, active-low; 0 = in reset.
//  - io_pc               out  XLEN  fetch address to fetch wrapper; held stable while io_mem_flag=1.
//  - io_mem_flag         out  1     fetch request (AR valid) to fetch wrapper.
//  - io_inst_valid       in   1     fetched word valid (R valid).
//  - io_inst_ready       out  1     fetch response accept (R ready).
//  - io_inst             in   32    fetched instruction word.
//  - io_out_valid        out  1     decode entry valid.
//  - io_out_ready        in   1     decode accepts entry.
//  - io_out_pc           out  XLEN  PC of presented instruction.
//  - io_out_inst         out  32    presented instruction.
//  - io_redirect_valid   in   1     one-cycle pulse: flush and refetch from target.
//  - io_redirect_target  in   XLEN  new PC.
// BEHAVIOUR
//  - States: FETCH, DROP, HOLD. Registers: pc_q, tgt_q, inst_q, state.
//  - Reset (async, reset=0):
//    - state=FETCH, pc_q=RESET_PC, tgt_q=0, inst_q=0.
//    - io_mem_flag=0, io_inst_ready=0, io_out_valid=0 while reset is low.
//    - First request: io_mem_flag=1 on the first clock edge after reset deassertion.
//  - FETCH:
//    - io_mem_flag=1, io_pc=pc_q, io_inst_ready=1.
//    - On io_inst_valid: inst_q<=io_inst, go HOLD; io_out_valid=1 on the next cycle.
//  - DROP:
//    - Entered when a redirect lands in FETCH; tgt_q<=target.
//    - io_mem_flag=1 and io_pc=pc_q (old address) are held; the AXI request is never withdrawn mid-transaction.
//    - On io_inst_valid: word is discarded, pc_q<=tgt_q, go FETCH.
//    - A further redirect in DROP overwrites tgt_q; the last redirect wins.
//  - HOLD:
//    - io_out_valid=1, io_mem_flag=0, io_inst_ready=0.
//    - On io_out_ready: pc_q<=pc_q+4 (mod 2^XLEN, wraps silently), go FETCH.
//  - Redirect in HOLD:
//    - pc_q<=target, go FETCH; the held entry is killed.
//    - Redirect beats io_out_ready in the same cycle, so the entry is NOT consumed.
//    - io_out_valid may still be high in the redirect cycle; decode must qualify with redirect.
//  - Redirect in FETCH coinciding with io_inst_valid: word is discarded, pc_q<=target, stay FETCH (DROP is skipped).
//  - Minimum round trip: 1 idle cycle with io_mem_flag=0 between consecutive requests; each new address is a fresh AR.
//  - Outputs are registered state decodes: no combinational path from io_out_ready to io_mem_flag.
//  - io_out_pc=pc_q and io_out_inst=inst_q, both stable throughout HOLD.
// CONFIGURATION
//  - FETCH_MISALIGN_CHK_EN defined:
//    - Adds port io_out_misalign (out, 1).
//    - A redirect target with [1:0]!=0 issues no fetch; go HOLD with inst_q=32'h0000_0013, io_out_misalign=1, io_out_pc=target.
//    - This applies both directly and out of DROP.
//  - FETCH_MISALIGN_CHK_EN undefined:
//    - No io_out_misalign port.
//    - Target bits [1:0] are forced to 0 on load.
// STRUCTURE
//  - fetch_pkg:
//    - fetch_state_e {FETCH, DROP, HOLD}.
//    - FETCH_RESET_PC default.
//    - INST_NOP=32'h0000_0013.
//    - PC_STEP=4.
//  - Single flat module; next-PC mux and FSM are inline, no sub-module.
// TESTING
//  - Reset release, slave answers 2 cycles after io_mem_flag:
//    - io_pc=0x8000_0000 first.
//    - io_out_valid with io_out_pc=0x8000_0000.
//    - After io_out_ready, next io_pc=0x8000_0004.
//  - io_out_ready held 0 for 5 cycles in HOLD: io_mem_flag stays 0, io_out_inst/io_out_pc stable; release -> pc+4.
//  - Redirect to 0x8000_0100 one cycle after request, response 3 cycles later:
//    - io_pc stays at old address until io_inst_valid.
//    - Word is dropped, no io_out_valid.
//    - Next request io_pc=0x8000_0100.
//  - Redirect (0x8000_0200) and io_out_ready in the same HOLD cycle: entry not consumed, next io_pc=0x8000_0200.
//  - Two redirects (0x10 then 0x20) during DROP: refetch at 0x20 only.
//  - With FETCH_MISALIGN_CHK_EN, redirect to 0x8000_0102: no io_mem_flag, io_out_misalign=1, io_out_inst=0x13.
//  - reset pulled low mid-fetch: io_mem_flag drops asynchronously; after release, io_pc=RESET_PC.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the PC/fetch sequencer.
package fetch_pkg;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    DROP  = 2'd1,
    HOLD  = 2'd2
  } fetch_state_e;

  localparam logic [63:0] FETCH_RESET_PC = 64'h0000_0000_8000_0000;
  localparam logic [31:0] INST_NOP       = 32'h0000_0013;
  localparam logic [63:0] PC_STEP        = 64'd4;

  function automatic logic pc_misaligned(input logic [1:0] lsb);
    return (lsb != 2'b00);
  endfunction

endpackage

// File: rtl/fetch_ctrl.sv
// PC/fetch sequencer feeding decode; handles redirects, including ones landing mid-fetch.
// Optional FETCH_MISALIGN_CHK_EN turns misaligned redirect targets into a flagged NOP entry.
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int              XLEN     = 64,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(FETCH_RESET_PC)
) (
  input  logic            clock,
  input  logic            reset,
  output logic [XLEN-1:0] io_pc,
  output logic            io_mem_flag,
  input  logic            io_inst_valid,
  output logic            io_inst_ready,
  input  logic [31:0]     io_inst,
  output logic            io_out_valid,
  input  logic            io_out_ready,
  output logic [XLEN-1:0] io_out_pc,
  output logic [31:0]     io_out_inst,
`ifdef FETCH_MISALIGN_CHK_EN
  output logic            io_out_misalign,
`endif
  input  logic            io_redirect_valid,
  input  logic [XLEN-1:0] io_redirect_target
);

  fetch_state_e    state_r, state_n;
  logic [XLEN-1:0] pc_r, pc_n, tgt_r, tgt_n;
  logic [31:0]     inst_r, inst_n;
  logic            mem_flag_r, inst_ready_r, out_valid_r;
  logic            fire_s, nop_load_s;
  logic [XLEN-1:0] redir_pc_s, drop_pc_s;
  logic            redir_bad_s, tgt_bad_s, drop_bad_s;

`ifdef FETCH_MISALIGN_CHK_EN
  assign redir_pc_s  = io_redirect_target;
  assign redir_bad_s = pc_misaligned(io_redirect_target[1:0]);
  assign tgt_bad_s   = pc_misaligned(tgt_r[1:0]);
`else
  assign redir_pc_s  = {io_redirect_target[XLEN-1:2], 2'b00};
  assign redir_bad_s = 1'b0;
  assign tgt_bad_s   = 1'b0;
`endif

  // A later redirect during DROP replaces the pending target.
  assign drop_pc_s  = io_redirect_valid ? redir_pc_s  : tgt_r;
  assign drop_bad_s = io_redirect_valid ? redir_bad_s : tgt_bad_s;
  assign fire_s     = io_inst_valid && inst_ready_r;

  // Next-state, next-PC and entry capture.
  always_comb begin
    state_n    = state_r;
    pc_n       = pc_r;
    tgt_n      = tgt_r;
    inst_n     = inst_r;
    nop_load_s = 1'b0;
    case (state_r)
      FETCH: begin
        if (io_redirect_valid) begin
          if (mem_flag_r && !fire_s) begin
            state_n = DROP;
            tgt_n   = redir_pc_s;
          end else if (redir_bad_s) begin
            state_n    = HOLD;
            pc_n       = redir_pc_s;
            nop_load_s = 1'b1;
          end else begin
            pc_n = redir_pc_s;
          end
        end else if (fire_s) begin
          state_n = HOLD;
          inst_n  = io_inst;
        end else begin
          state_n = FETCH;
        end
      end
      DROP: begin
        tgt_n = drop_pc_s;
        if (fire_s) begin
          pc_n = drop_pc_s;
          if (drop_bad_s) begin
            state_n    = HOLD;
            nop_load_s = 1'b1;
          end else begin
            state_n = FETCH;
          end
        end else begin
          state_n = DROP;
        end
      end
      HOLD: begin
        // Redirect has priority over consumption: the held entry is killed.
        if (io_redirect_valid) begin
          pc_n = redir_pc_s;
          if (redir_bad_s) begin
            state_n    = HOLD;
            nop_load_s = 1'b1;
          end else begin
            state_n = FETCH;
          end
        end else if (io_out_ready) begin
          pc_n    = pc_r + XLEN'(PC_STEP);
          state_n = FETCH;
        end else begin
          state_n = HOLD;
        end
      end
      default: begin
        state_n = FETCH;
      end
    endcase
    inst_n = nop_load_s ? INST_NOP : inst_n;
  end

  // State and registered handshake outputs; a response always leaves one idle request cycle.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r      <= FETCH;
      pc_r         <= RESET_PC;
      tgt_r        <= {XLEN{1'b0}};
      inst_r       <= 32'h0000_0000;
      mem_flag_r   <= 1'b0;
      inst_ready_r <= 1'b0;
      out_valid_r  <= 1'b0;
    end else begin
      state_r      <= state_n;
      pc_r         <= pc_n;
      tgt_r        <= tgt_n;
      inst_r       <= inst_n;
      mem_flag_r   <= (state_n != HOLD) && !fire_s;
      inst_ready_r <= (state_n != HOLD) && !fire_s;
      out_valid_r  <= (state_n == HOLD);
    end
  end

`ifdef FETCH_MISALIGN_CHK_EN
  logic mis_r;

  // Misalign flag follows the NOP entry until it leaves HOLD.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      mis_r <= 1'b0;
    end else if (nop_load_s) begin
      mis_r <= 1'b1;
    end else if ((state_n != HOLD) || (state_r != HOLD)) begin
      mis_r <= 1'b0;
    end else begin
      mis_r <= mis_r;
    end
  end

  assign io_out_misalign = mis_r;
`endif

  assign io_pc         = pc_r;
  assign io_mem_flag   = mem_flag_r;
  assign io_inst_ready = inst_ready_r;
  assign io_out_valid  = out_valid_r;
  assign io_out_pc     = pc_r;
  assign io_out_inst   = inst_r;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl; expected values are hand-computed constants.
module tb_fetch_ctrl;

  logic        clock = 1'b0;
  logic        reset;
  logic [63:0] io_pc;
  logic        io_mem_flag;
  logic        io_inst_valid;
  logic        io_inst_ready;
  logic [31:0] io_inst;
  logic        io_out_valid;
  logic        io_out_ready;
  logic [63:0] io_out_pc;
  logic [31:0] io_out_inst;
`ifdef FETCH_MISALIGN_CHK_EN
  logic        io_out_misalign;
`endif
  logic        io_redirect_valid;
  logic [63:0] io_redirect_target;

  int passed = 0;
  int total  = 0;

  fetch_ctrl dut (
    .clock              (clock),
    .reset              (reset),
    .io_pc              (io_pc),
    .io_mem_flag        (io_mem_flag),
    .io_inst_valid      (io_inst_valid),
    .io_inst_ready      (io_inst_ready),
    .io_inst            (io_inst),
    .io_out_valid       (io_out_valid),
    .io_out_ready       (io_out_ready),
    .io_out_pc          (io_out_pc),
    .io_out_inst        (io_out_inst),
`ifdef FETCH_MISALIGN_CHK_EN
    .io_out_misalign    (io_out_misalign),
`endif
    .io_redirect_valid  (io_redirect_valid),
    .io_redirect_target (io_redirect_target)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic respond(input int delay, input logic [31:0] w);
    repeat (delay) tick();
    io_inst_valid = 1'b1;
    io_inst       = w;
    tick();
    io_inst_valid = 1'b0;
  endtask

  task automatic redirect(input logic [63:0] t);
    io_redirect_valid  = 1'b1;
    io_redirect_target = t;
    tick();
    io_redirect_valid  = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b0;
    io_inst_valid = 1'b0; io_inst = 32'h0; io_out_ready = 1'b0;
    io_redirect_valid = 1'b0; io_redirect_target = 64'h0;

    #3;
    chk("rst_flag", {63'd0, io_mem_flag}, 64'd0);
    chk("rst_ready", {63'd0, io_inst_ready}, 64'd0);
    chk("rst_outv", {63'd0, io_out_valid}, 64'd0);
    repeat (2) tick();
    chk("rst_flag_clk", {63'd0, io_mem_flag}, 64'd0);
    reset = 1'b1;

    tick();
    chk("first_flag", {63'd0, io_mem_flag}, 64'd1);
    chk("first_pc", io_pc, 64'h8000_0000);
    chk("first_ready", {63'd0, io_inst_ready}, 64'd1);

    respond(1, 32'h1111_1111);
    chk("hold_outv", {63'd0, io_out_valid}, 64'd1);
    chk("hold_flag", {63'd0, io_mem_flag}, 64'd0);
    chk("hold_outpc", io_out_pc, 64'h8000_0000);
    chk("hold_inst", {32'd0, io_out_inst}, 64'h1111_1111);

    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stall_flag", {63'd0, io_mem_flag}, 64'd0);
      chk("stall_pc", io_out_pc, 64'h8000_0000);
      chk("stall_inst", {32'd0, io_out_inst}, 64'h1111_1111);
    end
    io_out_ready = 1'b1;
    tick();
    io_out_ready = 1'b0;
    chk("step_flag", {63'd0, io_mem_flag}, 64'd1);
    chk("step_pc", io_pc, 64'h8000_0004);
    chk("step_outv", {63'd0, io_out_valid}, 64'd0);

    tick();
    redirect(64'h8000_0100);
    chk("drop_pc_held", io_pc, 64'h8000_0004);
    chk("drop_flag", {63'd0, io_mem_flag}, 64'd1);
    tick();
    chk("drop_pc_held2", io_pc, 64'h8000_0004);
    respond(1, 32'h2222_2222);
    chk("drop_no_outv", {63'd0, io_out_valid}, 64'd0);
    chk("drop_gap", {63'd0, io_mem_flag}, 64'd0);
    tick();
    chk("drop_refetch_flag", {63'd0, io_mem_flag}, 64'd1);
    chk("drop_refetch_pc", io_pc, 64'h8000_0100);

    respond(1, 32'h3333_3333);
    chk("h2_outpc", io_out_pc, 64'h8000_0100);
    io_out_ready = 1'b1;
    redirect(64'h8000_0200);
    io_out_ready = 1'b0;
    chk("rdr_rdy_pc", io_pc, 64'h8000_0200);
    chk("rdr_rdy_flag", {63'd0, io_mem_flag}, 64'd1);
    chk("rdr_rdy_outv", {63'd0, io_out_valid}, 64'd0);

    redirect(64'h0000_0000_0000_0010);
    redirect(64'h0000_0000_0000_0020);
    chk("dd_pc_held", io_pc, 64'h8000_0200);
    respond(1, 32'h4444_4444);
    chk("dd_no_outv", {63'd0, io_out_valid}, 64'd0);
    tick();
    chk("dd_pc", io_pc, 64'h0000_0000_0000_0020);

    io_inst_valid = 1'b1; io_inst = 32'h5555_5555;
    redirect(64'h8000_0300);
    io_inst_valid = 1'b0;
    chk("coin_outv", {63'd0, io_out_valid}, 64'd0);
    chk("coin_gap", {63'd0, io_mem_flag}, 64'd0);
    tick();
    chk("coin_pc", io_pc, 64'h8000_0300);

`ifdef FETCH_MISALIGN_CHK_EN
    redirect(64'h8000_0102);
    respond(1, 32'h6666_6666);
    chk("mis_flag", {63'd0, io_out_misalign}, 64'd1);
    chk("mis_inst", {32'd0, io_out_inst}, 64'h0000_0013);
    chk("mis_pc", io_out_pc, 64'h8000_0102);
    chk("mis_outv", {63'd0, io_out_valid}, 64'd1);
    tick();
    chk("mis_nofetch", {63'd0, io_mem_flag}, 64'd0);
    redirect(64'hFFFF_FFFF_FFFF_FFFC);
    chk("mis_clear", {63'd0, io_out_misalign}, 64'd0);
`else
    redirect(64'hFFFF_FFFF_FFFF_FFFE);
    chk("algn_pc_held", io_pc, 64'h8000_0300);
    respond(0, 32'h6666_6666);
    tick();
`endif
    chk("wrap_flag", {63'd0, io_mem_flag}, 64'd1);
    chk("wrap_fetch_pc", io_pc, 64'hFFFF_FFFF_FFFF_FFFC);
    respond(1, 32'h7777_7777);
    chk("wrap_outpc", io_out_pc, 64'hFFFF_FFFF_FFFF_FFFC);
    io_out_ready = 1'b1;
    tick();
    io_out_ready = 1'b0;
    chk("wrap_pc", io_pc, 64'h0000_0000_0000_0000);
    chk("wrap_flag2", {63'd0, io_mem_flag}, 64'd1);

    #2;
    reset = 1'b0;
    #1;
    chk("async_flag", {63'd0, io_mem_flag}, 64'd0);
    chk("async_ready", {63'd0, io_inst_ready}, 64'd0);
    chk("async_pc", io_pc, 64'h8000_0000);
    #3;
    reset = 1'b1;
    tick();
    chk("rel_flag", {63'd0, io_mem_flag}, 64'd1);
    chk("rel_pc", io_pc, 64'h8000_0000);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
